// File: rtl/debounce_multi.sv
// debounce_multi: N_CH independent pushbutton debouncers sharing one sample-tick prescaler.
// Each channel: optional inversion, 2-flop synchroniser, per-tick stable counter,
// debounced level with one-cycle rise/fall pulses.
// Optional auto-repeat is compiled in when macro DEBOUNCE_MULTI_REPEAT_EN is defined;
// otherwise o_repeat is tied to 0 and REPEAT_DELAY/REPEAT_PERIOD have no effect.
module debounce_multi #(
    parameter int N_CH          = 4,
    parameter int TICK_DIV      = 10,
    parameter int STABLE_TICKS  = 3,
    parameter int ACTIVE_LOW    = 0,
    parameter int REPEAT_DELAY  = 50,
    parameter int REPEAT_PERIOD = 10
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_pb,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_rise,
    output logic [N_CH-1:0] o_fall,
    output logic [N_CH-1:0] o_repeat,
    output logic            o_tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SMAX = SW'(STABLE_TICKS - 1);

    logic [N_CH-1:0] pb_in;
    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;
    logic [PW-1:0]   div_cnt;
    logic [PW-1:0]   div_nxt;
    logic [SW-1:0]   stab_cnt [N_CH];
    logic [N_CH-1:0] flip;

    // Polarity normalisation happens ahead of the first synchroniser flop.
    assign pb_in = (ACTIVE_LOW != 0) ? ~i_pb : i_pb;

    // Two-flop synchroniser, runs every clock regardless of the tick.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pb_in;
            sync2 <= sync1;
        end
    end

    // Next prescaler value: wraps to 0 after TICK_DIV-1.
    always_comb begin
        div_nxt = (div_cnt == PMAX) ? '0 : div_cnt + PW'(1);
    end

    // Prescaler and tick strobe; o_tick is high while div_cnt sits at TICK_DIV-1.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_cnt <= '0;
            o_tick  <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            o_tick  <= (div_nxt == PMAX);
        end
    end

    // A channel flips on the tick where its differing run reaches STABLE_TICKS.
    always_comb begin
        flip = '0;
        for (int i = 0; i < N_CH; i++) begin
            flip[i] = o_tick && (sync2[i] != o_level[i]) && (stab_cnt[i] == SMAX);
        end
    end

    // Stable counters, debounced level and edge pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_level <= '0;
            o_rise  <= '0;
            o_fall  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                stab_cnt[i] <= '0;
            end
        end else begin
            o_rise <= '0;
            o_fall <= '0;
            if (o_tick) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (flip[i]) begin
                        o_level[i]  <= ~o_level[i];
                        o_rise[i]   <= ~o_level[i];
                        o_fall[i]   <= o_level[i];
                        stab_cnt[i] <= '0;
                    end else if (sync2[i] != o_level[i]) begin
                        stab_cnt[i] <= stab_cnt[i] + SW'(1);
                    end else begin
                        stab_cnt[i] <= '0;
                    end
                end
            end
        end
    end

`ifdef DEBOUNCE_MULTI_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RDLY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPER = RW'(REPEAT_PERIOD);

    logic [RW-1:0]   rep_cnt [N_CH];
    logic [N_CH-1:0] rep_phase;   // 0: waiting out the initial delay, 1: periodic

    // Auto-repeat: pulse with the rise, after REPEAT_DELAY ticks, then every REPEAT_PERIOD ticks.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_repeat  <= '0;
            rep_phase <= '0;
            for (int i = 0; i < N_CH; i++) begin
                rep_cnt[i] <= '0;
            end
        end else begin
            o_repeat <= '0;
            for (int i = 0; i < N_CH; i++) begin
                if (flip[i] && !o_level[i]) begin
                    o_repeat[i]  <= 1'b1;
                    rep_cnt[i]   <= '0;
                    rep_phase[i] <= 1'b0;
                end else if (!o_level[i] || flip[i]) begin
                    // Released (or releasing this tick): stop and re-arm the delay.
                    rep_cnt[i]   <= '0;
                    rep_phase[i] <= 1'b0;
                end else if (o_tick) begin
                    if ((rep_cnt[i] + RW'(1)) == (rep_phase[i] ? RPER : RDLY)) begin
                        o_repeat[i]  <= 1'b1;
                        rep_cnt[i]   <= '0;
                        rep_phase[i] <= 1'b1;
                    end else begin
                        rep_cnt[i] <= rep_cnt[i] + RW'(1);
                    end
                end
            end
        end
    end
`else
    assign o_repeat = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi (N_CH=2, TICK_DIV=4, STABLE_TICKS=3,
// REPEAT_DELAY=5, REPEAT_PERIOD=2). Honours DEBOUNCE_MULTI_REPEAT_EN if defined.
module tb_debounce_multi;

  localparam int N  = 2;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int RD = 5;
  localparam int RP = 2;
  localparam int W  = 4 * N + 1;
`ifdef DEBOUNCE_MULTI_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [N-1:0] pb;
  logic [N-1:0] o_level, o_rise, o_fall, o_repeat;
  logic         o_tick;

  debounce_multi #(
    .N_CH(N), .TICK_DIV(TD), .STABLE_TICKS(ST), .ACTIVE_LOW(0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_pb(pb),
    .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall),
    .o_repeat(o_repeat), .o_tick(o_tick)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Input reaches the decision logic two clocks late; a tick acts on every
  // TD-th clock edge after reset; a level flips once ST consecutive ticks
  // saw the opposite value; repeats fire n ticks after the press where
  // n == 0, n == RD, or n > RD with (n-RD) a multiple of RP.
  logic [W-1:0] exp_q[$];
  logic [N-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall, m_rep, samp;
  logic         m_tick;
  int           e_cnt, tick_n, nrep;
  int           m_run[N];
  int           m_press[N];

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
        m_s1 = '0; m_s2 = '0; m_lvl = '0;
        e_cnt = 0; tick_n = 0;
        for (int c = 0; c < N; c++) begin
          m_run[c] = 0;
          m_press[c] = 0;
        end
      end else begin
        e_cnt++;
        samp = m_s2;
        m_s2 = m_s1;
        m_s1 = pb;
        m_rise = '0; m_fall = '0; m_rep = '0;
        if (e_cnt % TD == 0) begin
          tick_n++;
          for (int c = 0; c < N; c++) begin
            if (samp[c] != m_lvl[c]) m_run[c]++;
            else m_run[c] = 0;
            if (m_run[c] == ST) begin
              m_run[c] = 0;
              if (m_lvl[c]) m_fall[c] = 1'b1;
              else begin
                m_rise[c] = 1'b1;
                m_press[c] = tick_n;
                m_rep[c] = REP_EN;
              end
              m_lvl[c] = ~m_lvl[c];
            end else if (m_lvl[c]) begin
              nrep = tick_n - m_press[c];
              if (REP_EN && (nrep == RD || (nrep > RD && (nrep - RD) % RP == 0)))
                m_rep[c] = 1'b1;
            end
          end
        end
        m_tick = (e_cnt % TD == TD - 1);
        exp_q.push_back({m_lvl, m_rise, m_fall, m_rep, m_tick});
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] e;
  int cyc = 0;
  int rise_c[N], fall_c[N], rep_c[N];
  int rise_t;
  int rep_t[$];

  task automatic clr_counts();
    for (int c = 0; c < N; c++) begin
      rise_c[c] = 0; fall_c[c] = 0; rep_c[c] = 0;
    end
    rise_t = -1;
    rep_t.delete();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        check("rst_outputs", 32'({o_level, o_rise, o_fall, o_repeat, o_tick}), 32'd0);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("level",  32'(o_level),  32'(e[8:7]));
        check("rise",   32'(o_rise),   32'(e[6:5]));
        check("fall",   32'(o_fall),   32'(e[4:3]));
        check("repeat", 32'(o_repeat), 32'(e[2:1]));
        check("tick",   32'(o_tick),   32'(e[0]));
      end
      for (int c = 0; c < N; c++) begin
        if (o_rise[c]) rise_c[c]++;
        if (o_fall[c]) fall_c[c]++;
        if (o_repeat[c]) rep_c[c]++;
      end
      if (o_rise[0]) rise_t = cyc;
      if (o_repeat[0]) rep_t.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [N-1:0] v);
    @(posedge clk);
    #2 pb = v;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  int lat, k;
  logic [N-1:0] rv;

  initial begin
    pb  = '0;
    rst = 1'b1;
    clr_counts();
    wait_cycles(3);
    #2 rst = 1'b0;
    #1 check("reset_level", 32'(o_level), 32'd0);

    // Clean press on ch0, held 40 cycles.
    clr_counts();
    drive(2'b01);
    lat = 0;
    while (lat < 60 && !o_level[0]) begin
      @(posedge clk);
      #1 lat++;
    end
    check("press_lat_max", 32'(lat <= 2 + ST * TD), 32'd1);
    check("press_lat_min", 32'(lat >= 2 + (ST - 1) * TD + 1), 32'd1);
    wait_cycles(40 - lat);
    check("press_rise_cnt", 32'(rise_c[0]), 32'd1);
    check("press_ch1_quiet", 32'(rise_c[1] + fall_c[1]), 32'd0);
    check("press_level", 32'(o_level), 32'b01);

    // Release ch0 while pressing ch1 in the same cycle.
    clr_counts();
    drive(2'b10);
    wait_cycles(30);
    check("swap_fall0", 32'(fall_c[0]), 32'd1);
    check("swap_rise1", 32'(rise_c[1]), 32'd1);
    check("swap_level", 32'(o_level), 32'b10);
    drive(2'b00);
    wait_cycles(30);

    // ch0 bouncing every 3 cycles for 30 cycles, then held.
    clr_counts();
    for (int i = 0; i < 10; i++) begin
      drive(pb ^ 2'b01);
      wait_cycles(2);
    end
    drive(2'b01);
    wait_cycles(40);
    check("bounce_rise", 32'(rise_c[0]), 32'd1);
    check("bounce_fall", 32'(fall_c[0]), 32'd0);
    drive(2'b00);
    wait_cycles(30);

    // 5-cycle glitch on ch1.
    clr_counts();
    drive(2'b10);
    wait_cycles(4);
    drive(2'b00);
    wait_cycles(30);
    check("glitch_events", 32'(rise_c[1] + fall_c[1]), 32'd0);
    check("glitch_level", 32'(o_level), 32'd0);

    // Reset in the middle of a count, inputs held through and after reset.
    drive(2'b01);
    wait_cycles(30);
    drive(2'b11);
    wait_cycles(11);
    #2 rst = 1'b1;
    #1 check("rst_async", 32'({o_level, o_rise, o_fall, o_repeat, o_tick}), 32'd0);
    wait_cycles(3);
    #2 rst = 1'b0;
    k = 0;
    while (k < 40) begin
      @(posedge clk);
      #1 k++;
      if (o_rise != '0) break;
    end
    check("rst_fresh_cycles", 32'(k), 32'(ST * TD));
    check("rst_fresh_rise", 32'(o_rise), 32'b11);
    drive(2'b00);
    wait_cycles(30);

    // Long hold on ch0 for auto-repeat.
    clr_counts();
    drive(2'b01);
    wait_cycles(110);
    if (REP_EN) begin
      check("rep_count_min", 32'(rep_t.size() >= 4), 32'd1);
      if (rep_t.size() >= 3) begin
        check("rep_with_rise", 32'(rep_t[0]), 32'(rise_t));
        check("rep_delay", 32'(rep_t[1] - rep_t[0]), 32'(RD * TD));
        check("rep_period", 32'(rep_t[2] - rep_t[1]), 32'(RP * TD));
      end
    end else begin
      check("rep_off", 32'(rep_c[0] + rep_c[1]), 32'd0);
    end
    drive(2'b00);
    wait_cycles(30);

    // Randomised segments against the reference model.
    for (int s = 0; s < 150; s++) begin
      rv = 2'($urandom_range(0, 3));
      drive(rv);
      wait_cycles($urandom_range(1, 20));
    end
    wait_cycles(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 SHALL provide parameter N_CH, default 4: number of independent pushbutton channels (1..32).
REQ-002 SHALL provide parameter TICK_DIV, default 10: i_clk cycles per sample tick (>=1; 1 = tick every cycle).
REQ-003 SHALL provide parameter STABLE_TICKS, default 3: consecutive differing ticks required to accept a new level (>=1).
REQ-004 SHALL provide parameter ACTIVE_LOW, default 0: when 1, each i_pb bit is inverted before synchronisation.
REQ-005 SHALL provide parameters REPEAT_DELAY, default 50, and REPEAT_PERIOD, default 10: both in ticks, both >=1, used only under REQ-024.
REQ-006 i_clk  input  1  sole clock, rising-edge.
REQ-007 i_rst  input  1  asynchronous reset, active-high.
REQ-008 i_pb  input  N_CH  raw, asynchronous, bouncing button inputs.
REQ-009 o_level  output  N_CH  debounced level per channel, 1 = pressed.
REQ-010 o_rise  output  N_CH  one-cycle pulse when o_level goes 0->1.
REQ-011 o_fall  output  N_CH  one-cycle pulse when o_level goes 1->0.
REQ-012 o_repeat  output  N_CH  auto-repeat pulses (REQ-024); constant 0 when the feature is compiled out.
REQ-013 o_tick  output  1  one-cycle strobe marking each sample tick.

Function
REQ-014 Each channel SHALL pass through a 2-flop synchroniser clocked every i_clk cycle, independent of tick; ACTIVE_LOW inversion is applied before the first flop.
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; o_tick SHALL be 1 exactly in the cycle the count equals TICK_DIV-1; count width is clog2(TICK_DIV), min 1.
REQ-016 On each tick, per channel: if sync sample != o_level, stable counter increments; if equal, it clears to 0; between ticks it holds.
REQ-017 When the stable counter would reach STABLE_TICKS, o_level SHALL toggle at that edge and the counter SHALL clear; counter never exceeds STABLE_TICKS-1 in the register.
REQ-018 o_rise/o_fall SHALL assert in the same cycle o_level first shows its new value, for exactly one cycle, never both on one channel.
REQ-019 Latency from a clean input edge to o_level change: 2 sync cycles plus between (STABLE_TICKS-1)*TICK_DIV+1 and STABLE_TICKS*TICK_DIV cycles.
REQ-020 Any glitch not spanning STABLE_TICKS consecutive ticks SHALL produce no output change.
REQ-021 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-022 i_rst SHALL asynchronously clear synchronisers, prescaler, stable counters, repeat counters, o_level, o_rise, o_fall, o_repeat, o_tick to 0.
REQ-023 After reset release, the prescaler starts from 0; a channel pressed throughout reset SHALL need a full STABLE_TICKS run before o_rise; reset mid-count SHALL discard partial progress.

Configuration
REQ-024 With macro DEBOUNCE_MULTI_REPEAT_EN defined: o_repeat pulses one cycle together with o_rise, then on the tick REPEAT_DELAY ticks later while o_level stays 1, then every REPEAT_PERIOD ticks; release stops repeats immediately and re-arms the delay.
REQ-025 Without DEBOUNCE_MULTI_REPEAT_EN: no repeat logic is synthesised; o_repeat is tied to 0; REPEAT_DELAY/REPEAT_PERIOD are ignored.

Verification (N_CH=2, TICK_DIV=4, STABLE_TICKS=3)
REQ-026 Clean press ch0 held 40 cycles -> o_level[0]=1 within 2+12 cycles of edge, o_rise[0] exactly one cycle, ch1 outputs stay 0.
REQ-027 ch0 toggling every 3 cycles for 30 cycles then held high -> exactly one o_rise[0], no o_fall[0].
REQ-028 5-cycle high glitch on ch1 -> o_level[1], o_rise[1], o_fall[1] stay 0.
REQ-029 Release ch0 after stable press -> o_fall[0] one cycle, o_level[0]=0 within 14 cycles; simultaneous press of ch1 -> o_rise[1] independent.
REQ-030 i_rst asserted mid-run with counter at 2 -> all outputs 0 the same cycle; after release, held input needs 3 fresh ticks before o_rise.
REQ-031 With DEBOUNCE_MULTI_REPEAT_EN, REPEAT_DELAY=5, REPEAT_PERIOD=2, hold 20 ticks -> o_repeat at press tick +0, +5, +7, +9, ...; without macro o_repeat stays 0.
